ps2_key_encoder: RTL
====================

# ps2_key_encoder

Producer side of the 11-bit `ps2_key` event word that the core's keyboard decoder consumes. Receives the raw PS/2 keyboard serial stream (clock and data lines), deframes bytes, folds the E0/F0 prefixes into extended and released flags, and emits one toggle-marked event word per make or break code. Sits between the physical or user-port PS/2 pins and the input-mapping logic in `emu`, in the `clk_sys` domain.

## Interface
Parameters:
- `FILT`, default 8: consecutive identical `clk_sys` samples required before a filtered line changes level.
- `TIMEOUT_CYC`, default 24000: `clk_sys` cycles allowed between falling edges inside a frame before the frame is abandoned.

Ports:
- `clk_sys` in, 1: system clock.
- `RESET_N` in, 1: asynchronous, active-low reset.
- `ps2_clk_in` in, 1: raw PS/2 clock line, asynchronous.
- `ps2_data_in` in, 1: raw PS/2 data line, asynchronous.
- `ps2_key` out, 11: event word. Bit 10 toggles once per event; bit 9 is pressed (1 = make); bit 8 is extended (E0 prefix); bits 7:0 are the scancode.
- `rx_byte` out, 8: last correctly framed byte, for debug.
- `rx_strobe` out, 1: one-cycle pulse when `rx_byte` updates.
- `frame_err` out, 1: one-cycle pulse on a parity, start, stop or timeout error.

## Operation
- **Line conditioning.** Each line passes through a 2-FF synchronizer and then the `FILT` filter. A falling edge is the filtered clock going 1→0.
- **Deframing states.**
  - `IDLE`: waits for a falling edge; samples filtered data; 0 → `DATA`, 1 → start error.
  - `DATA`: 8 edges; bits shift in LSB first.
  - `PARITY`: one edge; odd parity over the data bits plus the parity bit is required.
  - `STOP`: one edge; data must be 1. The state then always returns to `IDLE`.
- **Timeout.** A counter reloads on every falling edge. If it reaches `TIMEOUT_CYC` in any state other than `IDLE`: return to `IDLE`, pulse `frame_err`, and clear both prefix flags.
- **Good byte** (valid parity and stop): update `rx_byte`, pulse `rx_strobe`, then classify the byte:
  - `E0`: set `ext`. No event.
  - `F0`: set `rel`. No event.
  - `E1`, `FA`, `AA`, `EE`, `FE`, `00`, `FF`: discarded. Flags are unchanged. No event.
  - Any other byte: `ps2_key <= {~ps2_key[10], ~rel, ext, byte}`, then clear `ext` and `rel`.
- **Bad byte** (parity or stop error): no `rx_strobe`, no event, pulse `frame_err`, clear both flags.
- Errors and events never occur in the same cycle.

## Timing
- **Reset values:** `ps2_key` = 0, `rx_byte` = 0, `rx_strobe` = 0, `frame_err` = 0, state `IDLE`, flags 0, filters at 1, synchronizers at 1.
- **Filter latency:** a pin change is visible after 2 + `FILT` cycles. Glitches shorter than `FILT` cycles are ignored.
- **Event latency:** `ps2_key`, `rx_strobe` and `frame_err` register 1 cycle after the cycle that detects the stop-bit falling edge.
- **Throughput:** there is no back-pressure. The consumer detects events by comparing bit 10, so back-to-back events only need to be at least one PS/2 frame apart, which is guaranteed.
- **Reset mid-frame:** the partial frame and any pending prefixes are discarded. The first complete frame after release decodes normally.
- **Start-bit error:** stay in `IDLE` and pulse `frame_err`.

## Structure
- **Package `ps2_pkg`:**
  - State enum (`IDLE`, `DATA`, `PARITY`, `STOP`).
  - Prefix constants: `PS2_EXT` = 8'hE0, `PS2_REL` = 8'hF0, `PS2_PAUSE` = 8'hE1.
  - Discard-code list.
- **Sub-module `ps2_line_filter`:** synchronizer plus `FILT` filter, parameterised by `FILT`, instantiated once per line. Outputs the filtered level and a one-cycle falling-edge pulse.
- **Top:** the deframing FSM, timeout counter, prefix flags and output registers.

## Test plan
- After reset, send frame 0x29 (Space make) → `ps2_key` = 11'h629; one `rx_strobe` with `rx_byte` = 8'h29.
- Then send F0, 29 → `ps2_key` = 11'h029. The F0 frame alone produces no change.
- Then send E0, 75 → `ps2_key` = 11'h775. Then send E0, F0, 75 → `ps2_key` = 11'h175.
- Send 0x14 with wrong parity → `ps2_key` unchanged, one `frame_err` pulse, no `rx_strobe`. Send F0, then bad parity, then 14 → event word = 11'h614 (make; flag cleared by the error), computed with bit 10 toggled from its prior value.
- **Glitch and timeout:**
  - A clock low pulse of `FILT`−2 cycles mid-idle → no state change.
  - Stop after 4 data bits for `TIMEOUT_CYC`+10 cycles → `frame_err` pulses once; the next frame 0x1C decodes to pressed, not extended, code 0x1C.
- Assert `RESET_N` low after 5 bits of a frame → all outputs read 0. After release, frame 0x16 → `ps2_key` = 11'h616.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard deframer and event encoder.
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      PARITY,
      STOP
   } ps2_state_t;

   localparam logic [7:0] PS2_EXT   = 8'hE0;
   localparam logic [7:0] PS2_REL   = 8'hF0;
   localparam logic [7:0] PS2_PAUSE = 8'hE1;

   // Bytes that are keyboard housekeeping (ack, self-test, echo, resend, overrun), not keys.
   localparam logic [7:0] PS2_DISCARD [7] = '{PS2_PAUSE, 8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF};

   function automatic logic is_discard(input logic [7:0] b);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < 7; i++)
         if (b == PS2_DISCARD[i]) hit = 1'b1;
      return hit;
   endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer plus a FILT-sample persistence filter for one PS/2 line.
module ps2_line_filter #(
   parameter int FILT = 8
) (
   input  logic clk_sys,
   input  logic RESET_N,
   input  logic raw,
   output logic level,
   output logic fall
);

   localparam int CW = (FILT < 2) ? 1 : $clog2(FILT);

   logic [1:0]    sync;
   logic [CW-1:0] cnt;

   // cnt counts consecutive synchronized samples that disagree with the filtered level.
   always_ff @(posedge clk_sys or negedge RESET_N) begin
      if (!RESET_N) begin
         sync  <= 2'b11;
         level <= 1'b1;
         cnt   <= '0;
         fall  <= 1'b0;
      end else begin
         sync <= {sync[0], raw};
         fall <= 1'b0;
         if (sync[1] == level) begin
            cnt <= '0;
         end else if (cnt == CW'(FILT - 1)) begin
            level <= sync[1];
            cnt   <= '0;
            fall  <= level;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/ps2_key_encoder.sv
// PS/2 keyboard deframer: folds E0/F0 prefixes into flags and emits toggle-marked key events.
module ps2_key_encoder
   import ps2_pkg::*;
#(
   parameter int FILT        = 8,
   parameter int TIMEOUT_CYC = 24000
) (
   input  logic        clk_sys,
   input  logic        RESET_N,
   input  logic        ps2_clk_in,
   input  logic        ps2_data_in,
   output logic [10:0] ps2_key,
   output logic [7:0]  rx_byte,
   output logic        rx_strobe,
   output logic        frame_err
);

   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   logic          clk_f, clk_fall, data_f;
   ps2_state_t    state;
   logic [2:0]    bit_cnt;
   logic [7:0]    shreg;
   logic          par_ok;
   logic          ext, rel;
   logic [TW-1:0] tcnt;

   ps2_line_filter #(.FILT(FILT)) u_clk_filt (
      .clk_sys (clk_sys),
      .RESET_N (RESET_N),
      .raw     (ps2_clk_in),
      .level   (clk_f),
      .fall    (clk_fall)
   );

   ps2_line_filter #(.FILT(FILT)) u_data_filt (
      .clk_sys (clk_sys),
      .RESET_N (RESET_N),
      .raw     (ps2_data_in),
      .level   (data_f),
      .fall    ()
   );

   always_ff @(posedge clk_sys or negedge RESET_N) begin
      if (!RESET_N) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         shreg     <= '0;
         par_ok    <= 1'b0;
         ext       <= 1'b0;
         rel       <= 1'b0;
         tcnt      <= '0;
         ps2_key   <= '0;
         rx_byte   <= '0;
         rx_strobe <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         rx_strobe <= 1'b0;
         frame_err <= 1'b0;

         if (clk_fall)
            tcnt <= '0;
         else if (state != IDLE)
            tcnt <= tcnt + TW'(1);

         // A stalled frame drops its partial byte and any pending prefix.
         if (state != IDLE && !clk_fall && tcnt == TW'(TIMEOUT_CYC - 1)) begin
            state     <= IDLE;
            frame_err <= 1'b1;
            ext       <= 1'b0;
            rel       <= 1'b0;
         end else if (clk_fall) begin
            case (state)
               IDLE: begin
                  if (!data_f) begin
                     state   <= DATA;
                     bit_cnt <= '0;
                  end else begin
                     frame_err <= 1'b1;
                  end
               end
               DATA: begin
                  shreg   <= {data_f, shreg[7:1]};
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) state <= PARITY;
               end
               PARITY: begin
                  par_ok <= ^{data_f, shreg};
                  state  <= STOP;
               end
               STOP: begin
                  state <= IDLE;
                  if (par_ok && data_f) begin
                     rx_byte   <= shreg;
                     rx_strobe <= 1'b1;
                     if (shreg == PS2_EXT) begin
                        ext <= 1'b1;
                     end else if (shreg == PS2_REL) begin
                        rel <= 1'b1;
                     end else if (!is_discard(shreg)) begin
                        ps2_key <= {~ps2_key[10], ~rel, ext, shreg};
                        ext     <= 1'b0;
                        rel     <= 1'b0;
                     end
                  end else begin
                     frame_err <= 1'b1;
                     ext       <= 1'b0;
                     rel       <= 1'b0;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
